// File: rtl/counter_pkg.sv
// Shared types and timing defaults for the up/down counter, its key-repeat
// generator and the display path.
package counter_pkg;

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_REPEAT
   } rpt_state_e;

   typedef enum logic {
      CNT_SAT,
      CNT_WRAP
   } cnt_mode_e;

   localparam int DEF_REPEAT_DELAY  = 25_000_000;
   localparam int DEF_REPEAT_PERIOD = 5_000_000;

endpackage

// File: rtl/key_repeat_gen.sv
// Hold-to-repeat generator: turns a held key level into one step after
// REPEAT_DELAY cycles, then one step every REPEAT_PERIOD cycles.
module key_repeat_gen
   import counter_pkg::*;
#(
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_hold,
   input  logic dec_hold,
   output logic rpt_up,
   output logic rpt_dn
);

   localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TW   = $clog2(TMAX);
   localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

   rpt_state_e      state_q, state_d;
   logic            dir_up_q, dir_up_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            hold_ok;

   // The latched key must still be the only one held; anything else aborts.
   assign hold_ok = dir_up_q ? (inc_hold & ~dec_hold) : (dec_hold & ~inc_hold);

   always_comb begin
      state_d  = state_q;
      dir_up_d = dir_up_q;
      timer_d  = timer_q;
      rpt_up   = 1'b0;
      rpt_dn   = 1'b0;
      case (state_q)
         RPT_IDLE: begin
            if (inc_hold ^ dec_hold) begin
               state_d  = RPT_DELAY;
               dir_up_d = inc_hold;
               timer_d  = '0;
            end
         end
         RPT_DELAY: begin
            if (!hold_ok) begin
               state_d = RPT_IDLE;
               timer_d = '0;
            end else if (timer_q == DLY_LAST) begin
               rpt_up  = dir_up_q;
               rpt_dn  = ~dir_up_q;
               timer_d = '0;
               state_d = RPT_REPEAT;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         RPT_REPEAT: begin
            if (!hold_ok) begin
               state_d = RPT_IDLE;
               timer_d = '0;
            end else if (timer_q == PER_LAST) begin
               rpt_up  = dir_up_q;
               rpt_dn  = ~dir_up_q;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = RPT_IDLE;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RPT_IDLE;
         dir_up_q <= 1'b0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         dir_up_q <= dir_up_d;
         timer_q  <= timer_d;
      end
   end

endmodule

// File: rtl/updown_sat_counter.sv
// Bounded up/down counter with saturate-or-wrap limiting, load/clear and
// ovf/udf pulses. Define AUTOREPEAT_EN to build the hold-to-repeat path.
module updown_sat_counter
   import counter_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int MIN_VAL       = 0,
   parameter int MAX_VAL       = 255,
   parameter int RST_VAL       = 0,
   parameter int STEP          = 1,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             inc_hold,
   input  logic             dec_hold,
   input  logic             wrap_en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] value,
   output logic             at_max,
   output logic             at_min,
   output logic             ovf,
   output logic             udf
);

   if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL ||
       longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_range
      $error("updown_sat_counter: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
   end
   if (RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_bad_rst
      $error("updown_sat_counter: RST_VAL outside [MIN_VAL, MAX_VAL]");
   end
   if (STEP < 1 || STEP > MAX_VAL - MIN_VAL) begin : g_bad_step
      $error("updown_sat_counter: STEP must be in [1, MAX_VAL-MIN_VAL]");
   end
   if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_rpt
      $error("updown_sat_counter: repeat delay and period must be >= 2");
   end

   localparam logic [WIDTH:0] MIN_E   = (WIDTH+1)'(MIN_VAL);
   localparam logic [WIDTH:0] MAX_E   = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0] STEP_E  = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0] RANGE_E = (WIDTH+1)'(MAX_VAL - MIN_VAL + 1);
   localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

   logic rpt_up, rpt_dn;

`ifdef AUTOREPEAT_EN
   key_repeat_gen #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_key_repeat_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_hold (inc_hold),
      .dec_hold (dec_hold),
      .rpt_up   (rpt_up),
      .rpt_dn   (rpt_dn)
   );
`else
   logic unused_holds;
   assign unused_holds = inc_hold ^ dec_hold;
   assign rpt_up = 1'b0;
   assign rpt_dn = 1'b0;
`endif

   logic [WIDTH-1:0] value_q, value_d;
   logic             at_max_q, at_max_d, at_min_q, at_min_d;
   logic             ovf_q, ovf_d, udf_q, udf_d;
   logic             up, down;
   logic [WIDTH:0]   cur_e, sum_e, lv_e;
   cnt_mode_e        mode;

   assign up    = inc | rpt_up;
   assign down  = dec | rpt_dn;
   assign mode  = wrap_en ? CNT_WRAP : CNT_SAT;
   assign cur_e = {1'b0, value_q};
   assign lv_e  = {1'b0, load_val};
   assign sum_e = cur_e + STEP_E;

   always_comb begin
      value_d = value_q;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      if (clr) begin
         value_d = RST_W;
      end else if (load) begin
         if (lv_e < MIN_E)      value_d = WIDTH'(MIN_E);
         else if (lv_e > MAX_E) value_d = WIDTH'(MAX_E);
         else                   value_d = load_val;
      end else if (up && !down) begin
         if (sum_e > MAX_E) begin
            ovf_d   = 1'b1;
            value_d = (mode == CNT_WRAP) ? WIDTH'(sum_e - RANGE_E) : WIDTH'(MAX_E);
         end else begin
            value_d = WIDTH'(sum_e);
         end
      end else if (down && !up) begin
         // Adding RANGE before subtracting keeps the wrap path non-negative.
         if (cur_e < MIN_E + STEP_E) begin
            udf_d   = 1'b1;
            value_d = (mode == CNT_WRAP) ? WIDTH'(cur_e + RANGE_E - STEP_E) : WIDTH'(MIN_E);
         end else begin
            value_d = WIDTH'(cur_e - STEP_E);
         end
      end
      at_max_d = ({1'b0, value_d} == MAX_E);
      at_min_d = ({1'b0, value_d} == MIN_E);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q  <= RST_W;
         at_max_q <= (RST_VAL == MAX_VAL);
         at_min_q <= (RST_VAL == MIN_VAL);
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         value_q  <= value_d;
         at_max_q <= at_max_d;
         at_min_q <= at_min_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   assign value  = value_q;
   assign at_max = at_max_q;
   assign at_min = at_min_q;
   assign ovf    = ovf_q;
   assign udf    = udf_q;

endmodule
